// File: rtl/dest_sel_ring_pkg.sv
// Shared constants and encodings for the rotating destination-register selector.
package dest_sel_pkg;

    // Largest supported destination-register count
    localparam int unsigned DEST_SEL_MAX_N = 16;

    // Step direction encoding for the DIR strobe
    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage

// File: rtl/dest_sel_ring_if.sv
// Decoder-side strobes and register-file-side select outputs of the selector.
interface dest_sel_ring_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned IW = $clog2(N);

    logic          ADV;
    logic          DIR;
    logic          LD;
    logic [IW-1:0] IDX;
    logic [IW-1:0] LIM;
    logic          CLR;
    logic [N-1:0]  SEL;
    logic [IW-1:0] CUR;
    logic          WRAP;
    logic          ERR;

    // Instruction-decoder side: issues strobes, observes the pointer
    modport master (
        output ADV, DIR, LD, IDX, LIM, CLR,
        input  SEL, CUR, WRAP, ERR
    );

    // Selector side
    modport slave (
        input  ADV, DIR, LD, IDX, LIM, CLR,
        output SEL, CUR, WRAP, ERR
    );
endinterface

// File: rtl/dest_sel_ring_onehot_dec.sv
// Binary index to one-hot decoder; also usable on the register-file write-enable path.
module onehot_dec
    import dest_sel_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [$clog2(N)-1:0] idx_i,
    output logic [N-1:0]         sel_o
);
    localparam int unsigned IW = $clog2(N);

    if (N < 2 || N > DEST_SEL_MAX_N) begin : g_bad_n
        $error("onehot_dec: N out of supported range");
    end

    // Compare the index against every position; out-of-range indices give all-zero
    always_comb begin
        sel_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_o[i] = (idx_i == IW'(i));
        end
    end
endmodule

// File: rtl/dest_sel_ring.sv
// Rotating pointer over N destination registers with programmable wrap limit,
// up/down stepping, direct load, wrap pulse and sticky out-of-range-load error.
module dest_sel_ring
    import dest_sel_pkg::*;
#(
    parameter int unsigned N         = 3,
    parameter int unsigned RESET_IDX = 0
) (
    input  logic           CLK,
    input  logic           RST,
    dest_sel_ring_if.slave bus
);
    localparam int unsigned   IW      = $clog2(N);
    localparam logic [IW:0]   N_EXT   = (IW+1)'(N);
    localparam logic [IW-1:0] L_MAX   = IW'(N - 1);
    localparam logic [IW-1:0] PTR_RST = IW'(RESET_IDX);

    if (N < 2 || N > DEST_SEL_MAX_N) begin : g_bad_n
        $error("dest_sel_ring: N out of supported range");
    end
    if (RESET_IDX >= N) begin : g_bad_reset_idx
        $error("dest_sel_ring: RESET_IDX must be below N");
    end

    logic [IW-1:0] ptr_q, ptr_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;
    logic [IW-1:0] lim_eff;
    logic [N-1:0]  sel;

    // Effective wrap point: limits beyond the last register clamp to N-1
    always_comb begin
        if ({1'b0, bus.LIM} >= N_EXT) begin
            lim_eff = L_MAX;
        end else begin
            lim_eff = bus.LIM;
        end
    end

    // Next pointer / wrap / error: load beats advance beats hold; every write is
    // bounded by lim_eff so the pointer never leaves 0..N-1
    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        err_d  = err_q & ~bus.CLR;
        if (bus.LD) begin
            if (bus.IDX <= lim_eff) begin
                ptr_d = bus.IDX;
            end else begin
                ptr_d = lim_eff;
                err_d = 1'b1;
            end
        end else if (bus.ADV) begin
            if (dir_e'(bus.DIR) == DIR_UP) begin
                // ptr above a lowered limit also wraps back to zero
                if (ptr_q >= lim_eff) begin
                    ptr_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + IW'(1);
                end
            end else begin
                if (ptr_q == '0) begin
                    ptr_d  = lim_eff;
                    wrap_d = 1'b1;
                end else if (ptr_q > lim_eff) begin
                    ptr_d = lim_eff;
                end else begin
                    ptr_d = ptr_q - IW'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q  <= PTR_RST;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    onehot_dec #(
        .N(N)
    ) u_dec (
        .idx_i(ptr_q),
        .sel_o(sel)
    );

    assign bus.SEL  = sel;
    assign bus.CUR  = ptr_q;
    assign bus.WRAP = wrap_q;
    assign bus.ERR  = err_q;
endmodule

// File: tb/tb_dest_sel_ring.sv
// Bench for dest_sel_ring: three instances (N=3, 5, 8) share one stimulus stream;
// a spec-level model predicts every output each cycle, plus literal spot checks.
module tb_dest_sel_ring;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adv = 1'b0, dir = 1'b0, ld = 1'b0, clr = 1'b0;
    logic [3:0] idx = '0, lim = '0;
    bit         checking = 1'b0;

    always #5 clk = ~clk;

    dest_sel_ring_if #(.N(3)) if3 ();
    dest_sel_ring_if #(.N(5)) if5 ();
    dest_sel_ring_if #(.N(8)) if8 ();

    assign if3.ADV = adv; assign if3.DIR = dir; assign if3.LD = ld; assign if3.CLR = clr;
    assign if5.ADV = adv; assign if5.DIR = dir; assign if5.LD = ld; assign if5.CLR = clr;
    assign if8.ADV = adv; assign if8.DIR = dir; assign if8.LD = ld; assign if8.CLR = clr;
    assign if3.IDX = idx[1:0]; assign if3.LIM = lim[1:0];
    assign if5.IDX = idx[2:0]; assign if5.LIM = lim[2:0];
    assign if8.IDX = idx[2:0]; assign if8.LIM = lim[2:0];

    dest_sel_ring #(.N(3), .RESET_IDX(0)) u_d3 (.CLK(clk), .RST(rst), .bus(if3));
    dest_sel_ring #(.N(5), .RESET_IDX(0)) u_d5 (.CLK(clk), .RST(rst), .bus(if5));
    dest_sel_ring #(.N(8), .RESET_IDX(0)) u_d8 (.CLK(clk), .RST(rst), .bus(if8));

    // ---------------- model ----------------
    int unsigned NS  [3] = '{3, 5, 8};
    int unsigned IWS [3] = '{2, 3, 3};
    int unsigned mptr[3];
    bit          mwrap[3];
    bit          merr [3];

    int vectors     = 0;
    int miscompares = 0;

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            mptr[d]  = 0;
            mwrap[d] = 1'b0;
            merr[d]  = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int d = 0; d < 3; d++) begin
            int unsigned mask, li, ix, l;
            mask = (1 << IWS[d]) - 1;
            li   = lim & mask;
            ix   = idx & mask;
            l    = (li >= NS[d]) ? NS[d] - 1 : li;
            if (clr) merr[d] = 1'b0;
            mwrap[d] = 1'b0;
            if (ld) begin
                if (ix <= l) mptr[d] = ix;
                else begin
                    mptr[d] = l;
                    merr[d] = 1'b1;
                end
            end else if (adv && !dir) begin
                if (mptr[d] >= l) begin
                    mptr[d]  = 0;
                    mwrap[d] = 1'b1;
                end else mptr[d] = mptr[d] + 1;
            end else if (adv && dir) begin
                if (mptr[d] == 0) begin
                    mptr[d]  = l;
                    mwrap[d] = 1'b1;
                end else if (mptr[d] > l) mptr[d] = l;
                else mptr[d] = mptr[d] - 1;
            end
        end
    endfunction

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int unsigned sel_of(int d);
        case (d)
            0: return 32'(if3.SEL);
            1: return 32'(if5.SEL);
            default: return 32'(if8.SEL);
        endcase
    endfunction

    function automatic int unsigned cur_of(int d);
        case (d)
            0: return 32'(if3.CUR);
            1: return 32'(if5.CUR);
            default: return 32'(if8.CUR);
        endcase
    endfunction

    function automatic int unsigned wrap_of(int d);
        case (d)
            0: return 32'(if3.WRAP);
            1: return 32'(if5.WRAP);
            default: return 32'(if8.WRAP);
        endcase
    endfunction

    function automatic int unsigned err_of(int d);
        case (d)
            0: return 32'(if3.ERR);
            1: return 32'(if5.ERR);
            default: return 32'(if8.ERR);
        endcase
    endfunction

    // Compare every instance against the model away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 3; d++) begin
                int unsigned s;
                s = sel_of(d);
                chk($sformatf("sel_n%0d", NS[d]),    s,          32'd1 << mptr[d]);
                chk($sformatf("onehot_n%0d", NS[d]), (s != 0 && (s & (s - 1)) == 0) ? 1 : 0, 1);
                chk($sformatf("cur_n%0d", NS[d]),    cur_of(d),  mptr[d]);
                chk($sformatf("wrap_n%0d", NS[d]),   wrap_of(d), 32'(mwrap[d]));
                chk($sformatf("err_n%0d", NS[d]),    err_of(d),  32'(merr[d]));
            end
        end
    end

    always @(negedge clk) begin
        a_onehot: assert ($onehot(if3.SEL) && $onehot(if5.SEL) && $onehot(if8.SEL))
            else $error("select vector not one-hot");
    end

    // One clock: model follows the DUT on the same edge, inputs change 1 after it
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic idle();
        adv = 1'b0; dir = 1'b0; ld = 1'b0; clr = 1'b0;
    endtask

    typedef struct {
        bit       adv, dir, ld, clr;
        bit [3:0] idx, lim;
    } vec_t;

    vec_t tbl[16] = '{
        '{1, 0, 0, 0, 4'd0, 4'd15}, '{1, 0, 0, 0, 4'd0, 4'd15}, '{1, 0, 0, 0, 4'd0, 4'd15},
        '{1, 1, 0, 0, 4'd0, 4'd15}, '{1, 1, 0, 0, 4'd0, 4'd15}, '{1, 1, 0, 0, 4'd0, 4'd15},
        '{1, 1, 0, 0, 4'd0, 4'd15}, '{0, 0, 1, 0, 4'd9, 4'd15}, '{0, 0, 1, 0, 4'd7, 4'd15},
        '{1, 1, 0, 1, 4'd0, 4'd2},  '{1, 0, 0, 0, 4'd0, 4'd1},  '{1, 0, 0, 0, 4'd0, 4'd1},
        '{0, 0, 0, 1, 4'd0, 4'd1},  '{1, 1, 0, 0, 4'd0, 4'd6},  '{1, 1, 0, 0, 4'd0, 4'd6},
        '{0, 0, 1, 1, 4'd3, 4'd2}
    };

    initial begin
        idle();
        lim = 4'd2;
        rst = 1'b1;
        model_reset();
        checking = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset values, N=3
        chk("rst_sel3",  32'(if3.SEL),  32'b001);
        chk("rst_cur3",  32'(if3.CUR),  0);
        chk("rst_wrap3", 32'(if3.WRAP), 0);
        chk("rst_err3",  32'(if3.ERR),  0);

        // Advance once, then reset asynchronously between edges
        adv = 1'b1;
        cyc();
        adv = 1'b0;
        chk("cur3_pre_rst", 32'(if3.CUR), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_sel3", 32'(if3.SEL), 32'b001);
        chk("async_rst_cur3", 32'(if3.CUR), 0);
        cyc();
        rst = 1'b0;

        // N=5, LIM=4: count up and wrap
        lim = 4'd4;
        dir = 1'b0;
        adv = 1'b1;
        for (int unsigned i = 1; i <= 4; i++) begin
            cyc();
            chk("up_cur5", 32'(if5.CUR), i);
        end
        cyc();
        chk("wrap_cur5",  32'(if5.CUR),  0);
        chk("wrap_pulse5", 32'(if5.WRAP), 1);
        adv = 1'b0;
        cyc();
        chk("wrap_once5", 32'(if5.WRAP), 0);

        // Count down from 0 wraps to the limit
        dir = 1'b1;
        adv = 1'b1;
        cyc();
        chk("dn_cur5",  32'(if5.CUR),  4);
        chk("dn_wrap5", 32'(if5.WRAP), 1);
        cyc();
        chk("dn2_cur5",  32'(if5.CUR),  3);
        chk("dn2_wrap5", 32'(if5.WRAP), 0);
        idle();

        // N=8, LIM=5: out-of-range load clamps and sets sticky error
        lim = 4'd5;
        ld  = 1'b1;
        idx = 4'd6;
        cyc();
        ld = 1'b0;
        chk("badld_cur8", 32'(if8.CUR), 5);
        chk("badld_err8", 32'(if8.ERR), 1);
        adv = 1'b1;
        cyc();
        cyc();
        adv = 1'b0;
        chk("sticky_err8", 32'(if8.ERR), 1);
        chk("sticky_cur8", 32'(if8.CUR), 1);
        clr = 1'b1;
        cyc();
        chk("clr_err8", 32'(if8.ERR), 0);
        ld = 1'b1;
        cyc();
        idle();
        chk("clr_vs_set_err8", 32'(if8.ERR), 1);

        // Load beats advance
        ld  = 1'b1;
        adv = 1'b1;
        idx = 4'd2;
        cyc();
        idle();
        chk("ld_wins_cur8",  32'(if8.CUR),  2);
        chk("ld_wins_wrap8", 32'(if8.WRAP), 0);

        // Lowering the limit below the pointer, then degenerate limit 0
        lim = 4'd7;
        idx = 4'd6;
        ld  = 1'b1;
        cyc();
        ld = 1'b0;
        chk("ld6_cur8", 32'(if8.CUR), 6);
        lim = 4'd3;
        cyc();
        chk("lowlim_hold_cur8", 32'(if8.CUR), 6);
        adv = 1'b1;
        cyc();
        chk("lowlim_cur8",  32'(if8.CUR),  0);
        chk("lowlim_wrap8", 32'(if8.WRAP), 1);
        lim = 4'd0;
        for (int i = 0; i < 3; i++) begin
            dir = i[0];
            cyc();
            chk("lim0_cur8",  32'(if8.CUR),  0);
            chk("lim0_wrap8", 32'(if8.WRAP), 1);
        end
        idle();

        // Mixed directed vectors, model-checked on all three sizes
        for (int i = 0; i < 16; i++) begin
            adv = tbl[i].adv; dir = tbl[i].dir; ld = tbl[i].ld; clr = tbl[i].clr;
            idx = tbl[i].idx; lim = tbl[i].lim;
            cyc();
        end
        idle();
        cyc();
        @(negedge clk);
        #1;
        checking = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
